multicycle_sequencer: RTL and testbench
=======================================

Name: multicycle_sequencer

Overview:
Parametrised multicycle successor to the single-cycle RV32 datapath control. It owns the PC, the instruction register, the ALU-output and memory-data registers, and an FSM that shares one handshaked memory port between instruction fetch and data access. Branches are resolved inside the block. Outside it sit the reg_file, the ALU and the ALU/immediate decode; the sequencer drives them through its instruction and write-back outputs. It adds memory wait states, a timeout fault, an illegal-opcode fault, misalignment detection and a retired-instruction counter.

Parameters:
XLEN, 32, datapath and address width
PC_RESET, 0, PC value after reset (must be 4-byte aligned)
MEM_TIMEOUT, 15, maximum wait cycles for mem_ack before FAULT; 0 disables the timeout
CNT_W, 32, width of the retired-instruction counter

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
mem_req  out  1  memory request, held until acked
mem_we  out  1  1 = write (store), 0 = read
mem_addr  out  XLEN  byte address
mem_wdata  out  XLEN  store data
mem_rdata  in  XLEN  read data, valid with mem_ack
mem_ack  in  1  one-cycle completion strobe
alu_result  in  XLEN  external ALU output
alu_zero  in  1  external ALU zero flag
rs2_data  in  XLEN  reg_file read port 2
instr  out  32  instruction register
pc  out  XLEN  current PC
reg_we  out  1  reg_file write enable
wb_data  out  XLEN  reg_file write data
fault  out  1  sticky fault flag
retired  out  CNT_W  count of completed instructions

Behaviour:
- Reset (async, while reset=0):
  - state=FETCH, pc=PC_RESET, instr=0, alu_out register=0, MDR=0, retired=0, wait counter=0.
  - All outputs are 0 except pc.
  - mem_req drops immediately, even mid-transaction; an ack during reset is ignored.
- Outputs:
  - mem_req, mem_we, mem_addr, mem_wdata and reg_we are Moore outputs of state and registers.
  - mem_addr, mem_we and mem_wdata are stable for the whole request.
  - mem_ack is sampled only while mem_req=1; an ack with mem_req=0 is ignored.
- FETCH: mem_req=1, mem_we=0, mem_addr=pc. On ack: instr<=mem_rdata, then go to DECODE.
- DECODE (1 cycle), dispatch on opcode instr[6:0]:
  - 0110011 R, 0010011 I-ALU, 0000011 load, 0100011 store: go to EXECUTE.
  - 1100011 branch with funct3 000 (beq) or 001 (bne): go to EXECUTE.
  - Anything else: go to FAULT.
- EXECUTE (1 cycle): alu_out<=alu_result, then:
  - R / I-ALU: go to WB.
  - Load / store: go to MEM.
  - Branch: taken = alu_zero XOR funct3[0].
    - Taken: target = pc + sign-extended B-immediate, computed modulo 2^XLEN.
    - If target[1]=1: go to FAULT; pc and retired are unchanged.
    - Otherwise pc<=target.
    - Not taken: pc<=pc+4.
    - Then retired++ and go to FETCH.
- MEM: mem_req=1, mem_addr=alu_out, mem_we=(store), mem_wdata=rs2_data.
  - If alu_out[1:0]≠0: go to FAULT without asserting mem_req.
  - On ack, load: MDR<=mem_rdata, go to WB.
  - On ack, store: pc<=pc+4, retired++, go to FETCH.
- WB (1 cycle): reg_we=1, wb_data = MDR for a load, alu_out otherwise. Then pc<=pc+4, retired++, go to FETCH.
- Wait timer:
  - Counts cycles in FETCH/MEM with mem_req=1 and no ack; it clears on state entry and on ack.
  - When the count reaches MEM_TIMEOUT with no ack, go to FAULT on the next edge.
  - An ack on the same cycle the count reaches MEM_TIMEOUT wins (no fault).
- FAULT: fault=1, mem_req=0, reg_we=0. pc and instr are frozen at the faulting instruction. The state is left only by reset.
- Arithmetic: pc+4 wraps modulo 2^XLEN. retired wraps at 2^CNT_W with no flag.
- Latency with ack in the first request cycle:
  - R / I-ALU: 4 cycles
  - Load: 5 cycles
  - Store: 4 cycles
  - Branch: 3 cycles
  - Each extra wait cycle adds 1.

Decomposition:
- Shared package:
  - opcode constants (OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH)
  - funct3 BEQ/BNE
  - state enum {FETCH, DECODE, EXECUTE, MEM, WB, FAULT}
  - NOP encoding 32'h00000013
- Sub-module seq_wait_timer (parameter MEM_TIMEOUT): counter with clear/enable inputs and an expired output.
- B-immediate extraction stays inline.

Test Plan:
1. Reset, then memory at addr 0 returns 0x002081B3 (add x3,x1,x2) with ack in the first cycle, alu_result=0x5 -> reg_we=1 exactly in cycle 4 with wb_data=0x5; pc becomes 0x4; retired=1.
2. Load lw at pc=0, alu_result=0x100, data ack delayed 3 cycles returning 0xDEADBEEF -> mem_addr=0x100 stable for 4 cycles, mem_we=0; wb_data=0xDEADBEEF in cycle 8; retired=1.
3. beq with imm=+8 and alu_zero=1 at pc=0x10 -> pc=0x18 after 3 cycles. Same with alu_zero=0 -> pc=0x14. bne with alu_zero=0 -> pc=0x18.
4. Fetch returns 0xFFFFFFFF -> fault=1 after DECODE, pc unchanged, mem_req=0 forever. The fault clears only on reset.
5. mem_ack never arrives with MEM_TIMEOUT=15 -> fault=1 exactly 16 cycles after mem_req rises. An ack on wait cycle 15 -> no fault.
6. Assert reset mid-MEM of a store -> mem_req=0 in the same cycle (asynchronous). On release pc=PC_RESET, retired=0, and FETCH restarts.

Source files
------------

// File: rtl/multicycle_sequencer_pkg.sv
// multicycle_sequencer_pkg: opcodes, funct3 codes and FSM states shared by the sequencer
package multicycle_sequencer_pkg;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [2:0] F3_BEQ    = 3'b000;
  localparam logic [2:0] F3_BNE    = 3'b001;
  localparam logic [31:0] NOP      = 32'h0000_0013;
  typedef enum logic [2:0] {FETCH, DECODE, EXECUTE, MEM, WB, FAULT} state_t;
endpackage

// File: rtl/multicycle_sequencer_seq_wait_timer.sv
// seq_wait_timer: counts memory wait cycles and flags when the timeout is reached
module seq_wait_timer #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int W = MEM_TIMEOUT > 0 ? $clog2(MEM_TIMEOUT + 1) : 1;
  logic [W-1:0] count;
  // saturating wait counter; a zero timeout never expires
  always_ff @(posedge clock or negedge reset)
    if (!reset) count <= '0;
    else if (clr) count <= '0;
    else if (en && !expired) count <= count + 1'b1;
  assign expired = (MEM_TIMEOUT != 0) && (count == W'(MEM_TIMEOUT));
endmodule

// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer: RV32 multicycle control with a shared handshaked memory port
module multicycle_sequencer
  import multicycle_sequencer_pkg::*;
#(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] PC_RESET = '0,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset,
  output logic             mem_req,
  output logic             mem_we,
  output logic [XLEN-1:0]  mem_addr,
  output logic [XLEN-1:0]  mem_wdata,
  input  logic [XLEN-1:0]  mem_rdata,
  input  logic             mem_ack,
  input  logic [XLEN-1:0]  alu_result,
  input  logic             alu_zero,
  input  logic [XLEN-1:0]  rs2_data,
  output logic [31:0]      instr,
  output logic [XLEN-1:0]  pc,
  output logic             reg_we,
  output logic [XLEN-1:0]  wb_data,
  output logic             fault,
  output logic [CNT_W-1:0] retired
);
  state_t state, next_state;
  logic [XLEN-1:0] alu_out, mdr, b_imm, target;
  logic is_r, is_i, is_load, is_store, is_branch, legal, taken, ack, expired, retire;
  assign is_r      = instr[6:0] == OP_R;
  assign is_i      = instr[6:0] == OP_I;
  assign is_load   = instr[6:0] == OP_LOAD;
  assign is_store  = instr[6:0] == OP_STORE;
  assign is_branch = instr[6:0] == OP_BRANCH;
  assign legal     = is_r || is_i || is_load || is_store ||
                     (is_branch && (instr[14:12] == F3_BEQ || instr[14:12] == F3_BNE));
  assign taken     = alu_zero ^ instr[12];
  assign b_imm     = {{(XLEN-12){instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
  assign target    = pc + b_imm;
  assign ack       = mem_ack && mem_req;
  // every transition back into FETCH completes an instruction
  assign retire    = next_state == FETCH && state != FETCH;
  seq_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clock   (clock),
    .reset   (reset),
    .clr     (state != next_state || ack),
    .en      (mem_req),
    .expired (expired)
  );
  // state register
  always_ff @(posedge clock or negedge reset)
    if (!reset) state <= FETCH;
    else state <= next_state;
  // next-state logic; an ack on the expiry cycle still wins
  always_comb begin
    next_state = state;
    case (state)
      FETCH:   next_state = ack ? DECODE : expired ? FAULT : FETCH;
      DECODE:  next_state = legal ? EXECUTE : FAULT;
      EXECUTE: next_state = is_branch ? ((taken && target[1]) ? FAULT : FETCH)
                                      : (is_load || is_store) ? MEM : WB;
      MEM:     next_state = alu_out[1:0] != 2'b00 ? FAULT
                          : ack ? (is_store ? FETCH : WB)
                          : expired ? FAULT : MEM;
      WB:      next_state = FETCH;
      default: next_state = FAULT;
    endcase
  end
  // Moore outputs; the reset pin gates the request so it drops asynchronously
  always_comb begin
    mem_req   = reset && (state == FETCH || (state == MEM && alu_out[1:0] == 2'b00));
    mem_we    = mem_req && state == MEM && is_store;
    mem_addr  = mem_req ? (state == MEM ? alu_out : pc) : '0;
    mem_wdata = mem_we ? rs2_data : '0;
    reg_we    = state == WB;
    wb_data   = is_load ? mdr : alu_out;
    fault     = state == FAULT;
  end
  // datapath registers: PC, IR, ALU-out, MDR and retired counter
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      pc      <= PC_RESET;
      instr   <= '0;
      alu_out <= '0;
      mdr     <= '0;
      retired <= '0;
    end else begin
      if (state == FETCH && ack) instr <= mem_rdata;
      if (state == EXECUTE) alu_out <= alu_result;
      if (state == MEM && ack && is_load) mdr <= mem_rdata;
      if (retire) begin
        pc      <= (state == EXECUTE && taken) ? target : pc + XLEN'(4);
        retired <= retired + 1'b1;
      end
    end
endmodule

// File: tb/tb_multicycle_sequencer.sv
// tb_multicycle_sequencer: directed and random instruction runs against an instruction-level model
module tb_multicycle_sequencer;
  localparam int TO = 15;
  logic clock = 0, reset = 0;
  logic mem_req, mem_we, mem_ack = 0, alu_zero = 0, reg_we, fault;
  logic [31:0] mem_addr, mem_wdata, mem_rdata = 0, alu_result = 0, rs2_data = 0;
  logic [31:0] instr, pc, wb_data, retired;
  logic [31:0] m_pc = 0, m_ret = 0;
  int checks = 0, errors = 0;

  multicycle_sequencer #(.XLEN(32), .PC_RESET(32'h0), .MEM_TIMEOUT(TO), .CNT_W(32)) dut (
    .clock(clock), .reset(reset), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .alu_result(alu_result),
    .alu_zero(alu_zero), .rs2_data(rs2_data), .instr(instr), .pc(pc), .reg_we(reg_we),
    .wb_data(wb_data), .fault(fault), .retired(retired)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    mem_ack = 0;
    reset = 0;
    #1;
    chk("rst pc", pc, 0);
    chk("rst retired", retired, 0);
    chk("rst mem_req", mem_req, 0);
    chk("rst fault", fault, 0);
    chk("rst reg_we", reg_we, 0);
    chk("rst instr", instr, 0);
    chk("rst wb_data", wb_data, 0);
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset = 1;
    #1;
    m_pc = 0;
    m_ret = 0;
  endtask

  // Runs one instruction from its first FETCH cycle, acking fetch after fw and data after dw wait cycles.
  task automatic run_instr(input logic [31:0] w, input logic [31:0] alu, input logic z,
                           input logic [31:0] rs2, input int fw, input int dw, input logic [31:0] rd);
    logic ld, st, br, al, legal, tk, exp_f, exp_we, exp_data, mis;
    logic signed [12:0] bi;
    logic [31:0] tgt, exp_pc, exp_wb, a0, faddr, daddr, dwd;
    logic in_req, is_d, stable, done, dwe;
    int exp_lat, cyc, wcnt, nreq, dcyc, we_cnt, we_cyc;
    logic [31:0] wbv;
    ld = w[6:0] == 7'h03; st = w[6:0] == 7'h23; br = w[6:0] == 7'h63;
    al = w[6:0] == 7'h33 || w[6:0] == 7'h13;
    legal = ld || st || al || (br && w[14:13] == 2'b00);
    bi = {w[31], w[7], w[30:25], w[11:8], 1'b0};
    tgt = m_pc + 32'(int'(bi));
    mis = alu[1:0] != 2'b00;
    exp_pc = m_pc + 4; exp_f = 0; exp_we = 0; exp_data = 0; exp_wb = 0;
    if (fw > TO) begin exp_f = 1; exp_lat = TO + 1; end
    else if (!legal) begin exp_f = 1; exp_lat = fw + 2; end
    else if (br) begin
      tk = z ^ w[12];
      exp_lat = fw + 3;
      if (tk && tgt[1]) exp_f = 1;
      else if (tk) exp_pc = tgt;
    end else if (al) begin exp_lat = fw + 4; exp_we = 1; exp_wb = alu; end
    else if (mis) begin exp_f = 1; exp_lat = fw + 4; end
    else begin
      exp_data = 1;
      if (dw > TO) begin exp_f = 1; exp_lat = fw + 3 + TO + 1; end
      else begin
        exp_lat = fw + 4 + dw + (ld ? 1 : 0);
        if (ld) begin exp_we = 1; exp_wb = rd; end
      end
    end
    alu_result = alu; alu_zero = z; rs2_data = rs2;
    cyc = 0; wcnt = 0; nreq = 0; dcyc = 0; we_cnt = 0; we_cyc = 0; wbv = 0;
    in_req = 0; is_d = 0; stable = 1; done = 0; a0 = 0; faddr = 0; daddr = 0; dwd = 0; dwe = 0;
    while (!done && cyc < 60) begin
      cyc++;
      if (mem_req) begin
        if (!in_req) begin
          in_req = 1; wcnt = 0; is_d = nreq > 0; nreq++; a0 = mem_addr;
          if (!is_d) faddr = mem_addr;
        end else if (mem_addr !== a0) stable = 0;
        if (is_d) begin daddr = mem_addr; dwe = mem_we; dwd = mem_wdata; dcyc++; end
        else if (mem_we !== 1'b0) stable = 0;
        mem_rdata = is_d ? rd : w;
        mem_ack = wcnt == (is_d ? dw : fw);
        wcnt++;
        if (mem_ack) in_req = 0;
      end else begin
        mem_ack = 0; in_req = 0;
      end
      if (reg_we) begin we_cnt++; wbv = wb_data; we_cyc = cyc; end
      @(posedge clock); #1;
      done = (retired !== m_ret) || fault;
    end
    mem_ack = 0;
    chk("completed", done, 1);
    chk("latency", cyc, exp_lat);
    chk("fault", fault, exp_f);
    chk("pc", pc, exp_f ? m_pc : exp_pc);
    chk("retired", retired, exp_f ? m_ret : m_ret + 1);
    chk("fetch addr", faddr, m_pc);
    chk("addr stable", stable, 1);
    chk("reg_we count", we_cnt, exp_we);
    if (exp_we) begin
      chk("wb_data", wbv, exp_wb);
      chk("reg_we cycle", we_cyc, exp_lat);
    end
    if (exp_data) begin
      chk("data addr", daddr, alu);
      chk("data we", dwe, st);
      if (st) chk("store data", dwd, rs2);
      if (!exp_f) chk("data cycles", dcyc, dw + 1);
    end
    if ((ld || st) && mis && fw <= TO) chk("misaligned no req", nreq, 1);
    if (!exp_f) begin
      m_pc = exp_pc;
      m_ret = m_ret + 1;
    end else begin
      repeat (3) begin
        mem_ack = 1;
        @(posedge clock); #1;
        chk("fault hold", fault, 1);
        chk("fault mem_req", mem_req, 0);
        chk("fault pc", pc, m_pc);
        if (fw <= TO) chk("fault instr", instr, w);
      end
      do_reset();
    end
  endtask

  initial begin
    logic [31:0] r, w, a;
    int k, fw, dw;
    logic seen;
    #3;
    do_reset();
    run_instr(32'h002081B3, 32'h5, 0, 0, 0, 0, 0);
    run_instr(32'h0000A183, 32'h100, 0, 0, 0, 3, 32'hDEADBEEF);
    repeat (2) run_instr(32'h00000013, 32'h0, 0, 0, 0, 0, 0);
    chk("pc at 0x10", m_pc, 32'h10);
    run_instr(32'h00000463, 0, 1, 0, 0, 0, 0);
    run_instr(32'h00000463, 0, 0, 0, 0, 0, 0);
    run_instr(32'h00001463, 0, 0, 0, 0, 0, 0);
    run_instr(32'h0020A023, 32'h200, 0, 32'h12345678, 1, 2, 0);
    run_instr(32'hFFFFFFFF, 0, 0, 0, 0, 0, 0);
    run_instr(32'h00000013, 0, 0, 0, 100, 0, 0);
    run_instr(32'h00000013, 32'h7, 0, 0, 15, 0, 0);
    run_instr(32'h0000A183, 32'h40, 0, 0, 0, 15, 32'hCAFE0001);
    run_instr(32'h0000A183, 32'h40, 0, 0, 0, 40, 0);
    run_instr(32'h0020A023, 32'h41, 0, 32'h1, 0, 0, 0);
    run_instr(32'h00000263, 0, 1, 0, 0, 0, 0);
    run_instr(32'h00000013, 32'h3, 0, 0, 0, 0, 0);
    run_instr(32'h0020A023, 32'h80, 0, 32'h55, 0, 0, 0);
    alu_result = 32'h40; rs2_data = 32'hAA; seen = 0;
    mem_rdata = 32'h0020A023;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (mem_req && mem_we) seen = 1;
      else begin
        mem_ack = mem_req;
        @(posedge clock); #1;
      end
    end
    chk("store req seen", seen, 1);
    chk("pre-reset pc nonzero", pc != 0, 1);
    mem_ack = 1;
    #2;
    reset = 0;
    #1;
    chk("async req drop", mem_req, 0);
    chk("async pc", pc, 0);
    chk("async retired", retired, 0);
    @(posedge clock); #1;
    chk("ack ignored in reset", mem_req, 0);
    do_reset();
    chk("restart req", mem_req, 1);
    chk("restart addr", mem_addr, 0);
    chk("restart we", mem_we, 0);
    for (int n = 0; n < 45; n++) begin
      r = $urandom();
      a = $urandom();
      if ($urandom_range(0, 7) != 0) a[1:0] = 2'b00;
      k = $urandom_range(0, 9);
      fw = $urandom_range(0, 2);
      dw = ($urandom_range(0, 29) == 0) ? 20 : $urandom_range(0, 3);
      if (k <= 2 || k == 8) w = {r[31:7], (r[0] ? 7'h33 : 7'h13)};
      else if (k == 3 || k == 4) w = {r[31:15], 3'b010, r[11:7], (k == 3 ? 7'h03 : 7'h23)};
      else if (k <= 7) begin
        w = {r[31:15], 2'b00, r[12], r[11:7], 7'h63};
        if ($urandom_range(0, 4) != 0) w[8] = 1'b0;
      end else w = ($urandom_range(0, 3) == 0) ? {r[31:15], 3'b011, r[11:7], 7'h63}
                                                : {r[31:7], 7'h13};
      run_instr(w, a, 1'($urandom_range(0, 1)), $urandom(), fw, dw, $urandom());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
